// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out register.
// The state enum always lists PISO_PARITY. Only builds with PISO_PARITY_EN
// defined ever enter that state.
package piso_pkg;

  typedef enum logic [1:0] {
    PISO_IDLE   = 2'd0,
    PISO_SHIFT  = 2'd1,
    PISO_PARITY = 2'd2
  } piso_state_e;

endpackage

// File: rtl/bit_counter.sv
// Bit position counter for the serialiser.
// It counts up from 0 and flags when the count equals TERMINAL.
// clear has priority over en.
module bit_counter #(
  parameter int TERMINAL = 7,
  parameter int CNT_W    = (TERMINAL > 0) ? $clog2(TERMINAL + 1) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             at_term
);

  // Count register: clear restarts a frame, en advances one bit.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign at_term = (count == CNT_W'(TERMINAL));

endmodule

// File: rtl/piso_register.sv
// Parallel-in / serial-out register with a registered serial interface.
// - A word is accepted when load and ready are both high.
// - The first bit of the word appears one cycle after it is accepted.
// - shift_en=0 freezes the frame in place.
// - A load accepted on the final bit starts the next frame with no gap.
// Optional: define PISO_PARITY_EN to append an even-parity bit to each frame.
module piso_register
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_end
);

  localparam int CNT_W = $clog2(WIDTH);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, sreg_shift;
  logic             ser_out_d, ser_valid_d, frame_start_d, frame_end_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last, cnt_clear, cnt_en;
  logic             final_bit, accept, advance;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  bit_counter #(
    .TERMINAL (WIDTH - 1),
    .CNT_W    (CNT_W)
  ) u_bit_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear),
    .en      (cnt_en),
    .count   (cnt),
    .at_term (cnt_last)
  );

  // Next-state logic: accept, advance, wrap back to the next frame, or idle.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d       = state_q;
    sreg_d        = sreg_q;
    ser_valid_d   = ser_valid;
    frame_start_d = frame_start;
    frame_end_d   = frame_end;
    cnt_clear     = 1'b0;
    cnt_en        = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d      = parity_q;
    final_bit     = (state_q == PISO_PARITY);
`else
    final_bit     = (state_q == PISO_SHIFT) && cnt_last;
`endif
    ready      = (state_q == PISO_IDLE) || (final_bit && shift_en);
    accept     = load && ready;
    advance    = (state_q != PISO_IDLE) && shift_en;
    sreg_shift = (MSB_FIRST != 0) ? {sreg_q[WIDTH-2:0], 1'b0}
                                  : {1'b0, sreg_q[WIDTH-1:1]};

    if (accept) begin
      state_d       = PISO_SHIFT;
      sreg_d        = data_in;
      ser_valid_d   = 1'b1;
      frame_start_d = 1'b1;
      frame_end_d   = 1'b0;
      cnt_clear     = 1'b1;
`ifdef PISO_PARITY_EN
      parity_d      = ^data_in;
`endif
    end else if (advance) begin
      if (final_bit) begin
        state_d       = PISO_IDLE;
        sreg_d        = '0;
        ser_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        cnt_clear     = 1'b1;
`ifdef PISO_PARITY_EN
      end else if (cnt_last) begin
        state_d       = PISO_PARITY;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b1;
`endif
      end else begin
        sreg_d        = sreg_shift;
        cnt_en        = 1'b1;
        frame_start_d = 1'b0;
`ifdef PISO_PARITY_EN
        frame_end_d   = 1'b0;
`else
        frame_end_d   = (cnt == CNT_W'(WIDTH - 2));
`endif
      end
    end

    // The serial bit is always the head of the next shift register contents.
    ser_out_d = 1'b0;
    if (state_d == PISO_SHIFT) begin
      ser_out_d = (MSB_FIRST != 0) ? sreg_d[WIDTH-1] : sreg_d[0];
`ifdef PISO_PARITY_EN
    end else if (state_d == PISO_PARITY) begin
      ser_out_d = parity_q;
`endif
    end
  end

  // State, shift register and every serial-side output are flops.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the shift register is reset with the control state, so an aborted frame cannot leak bits.
    if (!rst_n) begin
      state_q     <= PISO_IDLE;
      sreg_q      <= '0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      ser_out     <= ser_out_d;
      ser_valid   <= ser_valid_d;
      frame_start <= frame_start_d;
      frame_end   <= frame_end_d;
`ifdef PISO_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_register.sv
// Scoreboard bench for piso_register.
// Two instances share the same inputs: one shifts MSB first, one LSB first.
// Bench structure:
// - Each accepted word pushes one record per frame bit into a queue.
// - A new word is accepted exactly when no untransmitted bit remains.
// - The monitor pops one record each cycle the presented bit is consumed
//   (shift_en=1).
// - The monitor checks held bits, idle outputs and ready against the queue.
// Build with PISO_PARITY_EN defined to exercise the parity frame.
module tb_piso_register;

  localparam int W = 8;

  typedef struct packed {
    logic bm;  // expected bit, MSB-first instance
    logic bl;  // expected bit, LSB-first instance
    logic fs;
    logic fe;
  } rec_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] data_in;
  logic         load;
  logic         shift_en;
  logic         ready_m, ser_out_m, ser_valid_m, frame_start_m, frame_end_m;
  logic         ready_l, ser_out_l, ser_valid_l, frame_start_l, frame_end_l;

  rec_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  piso_register #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .load        (load),
    .ready       (ready_m),
    .shift_en    (shift_en),
    .ser_out     (ser_out_m),
    .ser_valid   (ser_valid_m),
    .frame_start (frame_start_m),
    .frame_end   (frame_end_m)
  );

  piso_register #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .load        (load),
    .ready       (ready_l),
    .shift_en    (shift_en),
    .ser_out     (ser_out_l),
    .ser_valid   (ser_valid_l),
    .frame_start (frame_start_l),
    .frame_end   (frame_end_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Queue the records for one frame of word d.
  task automatic push_frame(input logic [W-1:0] d);
    rec_t r;
    for (int i = 0; i < W; i++) begin
      r.bm = d[W-1-i];
      r.bl = d[i];
      r.fs = (i == 0);
`ifdef PISO_PARITY_EN
      r.fe = 1'b0;
`else
      r.fe = (i == W - 1);
`endif
      q.push_back(r);
    end
`ifdef PISO_PARITY_EN
    r.bm = ^d;
    r.bl = ^d;
    r.fs = 1'b0;
    r.fe = 1'b1;
    q.push_back(r);
`endif
  endtask

  // Drive one cycle of inputs, starting just after a rising edge.
  // The monitor's negedge pop runs first. The word is then accepted only if
  // no bit is left to send.
  task automatic step(input logic ld, input logic [W-1:0] d, input logic se);
    load     = ld;
    data_in  = d;
    shift_en = se;
    @(negedge clk);
    #1;
    if (ld && rst_n && q.size() == 0) push_frame(d);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare what each DUT presents with the head of the queue.
  always @(negedge clk) begin
    logic exp_ready;
    rec_t r;
    exp_ready = (q.size() == 0) || (q.size() == 1 && shift_en);
    check("ready_msb", ready_m, exp_ready);
    check("ready_lsb", ready_l, exp_ready);
    if (q.size() == 0) begin
      check("idle_msb", {ser_valid_m, ser_out_m, frame_start_m, frame_end_m}, 4'b0000);
      check("idle_lsb", {ser_valid_l, ser_out_l, frame_start_l, frame_end_l}, 4'b0000);
    end else begin
      r = q[0];
      check("bit_msb", {ser_valid_m, ser_out_m, frame_start_m, frame_end_m},
            {1'b1, r.bm, r.fs, r.fe});
      check("bit_lsb", {ser_valid_l, ser_out_l, frame_start_l, frame_end_l},
            {1'b1, r.bl, r.fs, r.fe});
      if (shift_en) void'(q.pop_front());
    end
  end

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    data_in  = '0;
    shift_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {ser_valid_m, ser_out_m, frame_start_m, frame_end_m}, 4'b0000);
    check("reset_ready", ready_m, 1'b1);

    // Word loaded on the first edge after reset release; A5 then idle.
    rst_n = 1'b1;
    step(1'b1, 8'hA5, 1'b1);
    repeat (W + 2) step(1'b0, 8'h00, 1'b1);

    // Back-to-back frames, the second loaded on the final bit of the first.
    step(1'b1, 8'h3C, 1'b1);
    repeat (W - 1) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hC3, 1'b1);
    repeat (W + 2) step(1'b0, 8'h00, 1'b1);

    // Three-cycle stall on bit 2, with a load attempt that must be dropped.
    step(1'b1, 8'hF0, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    repeat (W + 2) step(1'b0, 8'h00, 1'b1);

    // Load on the final bit while stalled is dropped too.
    step(1'b1, 8'h81, 1'b1);
    repeat (W - 1) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h55, 1'b0);
    repeat (W + 2) step(1'b0, 8'h00, 1'b1);

    // Reset pulse while bit 4 of FF is presented.
    step(1'b1, 8'hFF, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {ser_valid_m, ser_out_m, frame_start_m, frame_end_m}, 4'b0000);
    check("midreset_ready", ready_m, 1'b1);
    q.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (W + 2) step(1'b0, 8'h00, 1'b1);

    // Single set bit: LSB instance sends 1 then seven 0s.
    step(1'b1, 8'h01, 1'b1);
    repeat (W + 2) step(1'b0, 8'h00, 1'b1);

    // Parity words: odd and even number of ones.
    step(1'b1, 8'h07, 1'b1);
    repeat (W + 2) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h03, 1'b1);
    repeat (W + 2) step(1'b0, 8'h00, 1'b1);

    // Randomised traffic with random stalls.
    repeat (600) step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0));

    // Drain everything still queued.
    repeat (3 * W) step(1'b0, 8'h00, 1'b1);
    check("drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
